// File: rtl/fir_decim_fifo.sv
// Decimating output buffer behind the FIR filter: keeps one of every D strobed samples
// and presents them first-word-fall-through over valid/ready, flagging drops when full.
module fir_decim_fifo #(
    parameter int unsigned BITWIDTH = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned DW       = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_enable,
    input  logic [BITWIDTH-1:0]     inP,
    input  logic [DW-1:0]           decim,
    input  logic                    ovf_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BITWIDTH-1:0]     out_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic [15:0]             drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = 1;

    logic [BITWIDTH-1:0] r_mem [DEPTH];
    logic [DW-1:0]       r_ph;
    logic [AW:0]         r_wr;
    logic [AW:0]         r_rd;
    logic                r_ovf;
    logic [15:0]         r_drop;

    logic [DW-1:0] w_dm1;
    logic [DW-1:0] w_ph_nxt;
    logic          w_keep;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_wr_en;
    logic          w_drop;

    always_comb begin
        // decim of 0 behaves as 1, so the wrap point is 0 in both cases
        w_dm1    = (decim == '0) ? '0 : decim - DW'(1);
        w_ph_nxt = (r_ph >= w_dm1) ? '0 : r_ph + DW'(1);
        w_keep   = in_enable & (r_ph == '0);
        w_empty  = (r_wr == r_rd);
        w_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
        w_pop    = ~w_empty & out_ready;
        w_wr_en  = resetn & w_keep & (~w_full | w_pop);
        w_drop   = w_keep & w_full & ~w_pop;
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr[AW-1:0]] <= inP;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ph   <= '0;
            r_wr   <= '0;
            r_rd   <= '0;
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else begin
            if (in_enable) begin
                r_ph <= w_ph_nxt;
            end
            if (w_wr_en) begin
                r_wr <= r_wr + PtrOne;
            end
            if (w_pop) begin
                r_rd <= r_rd + PtrOne;
            end
            // A drop in the clearing cycle wins, so the new event is never lost
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (ovf_clr) begin
                r_drop <= {15'b0, w_drop};
            end else if (w_drop && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    assign out_valid  = ~w_empty;
    assign out_data   = out_valid ? r_mem[r_rd[AW-1:0]] : '0;
    assign level      = r_wr - r_rd;
    assign overflow   = r_ovf;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Self-checking bench for fir_decim_fifo: vector table plus hand sequences, with a
// scoreboard queue filled at drive time and drained as the consumer pops.
module tb_fir_decim_fifo;

    localparam int DEPTH = 8;

    logic        clk;
    logic        resetn;
    logic        in_enable;
    logic [15:0] inP;
    logic [7:0]  decim;
    logic        ovf_clr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  level;
    logic        overflow;
    logic [15:0] drop_count;

    fir_decim_fifo #(
        .BITWIDTH(16),
        .DEPTH   (DEPTH),
        .DW      (8)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_enable (in_enable),
        .inP       (inP),
        .decim     (decim),
        .ovf_clr   (ovf_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic        en;
        logic [15:0] din;
        logic [7:0]  dec;
        logic        rdy;
        logic        clr;
        logic        e_valid;
        logic [15:0] e_data;
        logic [3:0]  e_level;
        logic        e_ovf;
        logic [15:0] e_drop;
    } vec_t;

    vec_t        tbl[$];
    int          total = 0;
    int          bad = 0;
    int          m_ph = 0;
    int          m_level = 0;
    bit          m_ovf = 0;
    int          m_drop = 0;
    logic [15:0] sb[$];
    logic [15:0] got[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rstn, en, input logic [15:0] din,
                                input logic [7:0] dec, input logic rdy, clr, ev,
                                input logic [15:0] ed, input logic [3:0] el,
                                input logic eo, input logic [15:0] edr);
        vec_t v;
        v.rstn = rstn; v.en = en; v.din = din; v.dec = dec; v.rdy = rdy; v.clr = clr;
        v.e_valid = ev; v.e_data = ed; v.e_level = el; v.e_ovf = eo; v.e_drop = edr;
        return v;
    endfunction

    // Drive one cycle, update the reference model, then check after the edge.
    task automatic step(input logic rstn_v, en_v, input logic [15:0] d,
                        input logic [7:0] dec, input logic rdy_v, clr_v);
        int dm1;
        bit keep, pop, full, drop;
        resetn = rstn_v; in_enable = en_v; inP = d; decim = dec;
        out_ready = rdy_v; ovf_clr = clr_v;
        if (!rstn_v) begin
            m_ph = 0; m_level = 0; m_ovf = 0; m_drop = 0;
            sb.delete();
        end else begin
            dm1  = (dec == 0) ? 0 : int'(dec) - 1;
            keep = en_v && (m_ph == 0);
            pop  = rdy_v && (m_level > 0);
            full = (m_level == DEPTH);
            drop = keep && full && !pop;
            if (en_v) m_ph = (m_ph >= dm1) ? 0 : m_ph + 1;
            if (keep && !drop) begin
                sb.push_back(d);
                m_level++;
            end
            if (pop) m_level--;
            if (clr_v) begin
                m_ovf = drop;
                m_drop = drop ? 1 : 0;
            end else if (drop) begin
                m_ovf = 1;
                if (m_drop < 65535) m_drop++;
            end
        end
        @(posedge clk);
        #1;
        chk("model_level", 32'(level), 32'(m_level));
        chk("model_valid", 32'(out_valid), 32'(m_level != 0));
        chk("model_ovf", 32'(overflow), 32'(m_ovf));
        chk("model_drop", 32'(drop_count), 32'(m_drop));
        if (m_level == 0) chk("idle_data", 32'(out_data), 32'd0);
    endtask

    // Consumer side: every accepted word must match the scoreboard head.
    always @(negedge clk) begin
        if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_pop", 32'(out_data), 32'hFFFFFFFF);
            end else begin
                chk("sb_data", 32'(out_data), 32'(sb.pop_front()));
            end
            got.push_back(out_data);
        end
    end

    initial begin
        resetn = 1'b0; in_enable = 1'b0; inP = '0; decim = 8'd1;
        out_ready = 1'b0; ovf_clr = 1'b0;

        // Reset row with a strobe present, then D=1 pass-through, then fill past full.
        tbl.push_back(mk(0, 1, 16'd55, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 4; k++)
            tbl.push_back(mk(1, 1, 16'(k), 1, 1, 0, 1, 16'(k), 1, 0, 0));
        tbl.push_back(mk(1, 0, 16'd0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'd0, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(1, 1, 16'(100 + k), 1, 0, 0, 1, 16'd100,
                             4'((k + 1 > 8) ? 8 : k + 1), k >= 8, 16'((k >= 8) ? k - 7 : 0)));
        for (int j = 0; j < 8; j++)
            tbl.push_back(mk(1, 0, 16'd0, 1, 1, 0, j < 7, 16'((j < 7) ? 101 + j : 0),
                             4'(7 - j), 1, 16'd2));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rstn, tbl[i].en, tbl[i].din, tbl[i].dec, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].e_data));
            chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].e_level));
            chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].e_ovf));
            chk($sformatf("tbl%0d_drop", i), 32'(drop_count), 32'(tbl[i].e_drop));
        end

        // D=3 with idle gaps: gaps must not move the selection.
        step(0, 0, 0, 3, 0, 0);
        got.delete();
        for (int v = 10; v <= 18; v++) begin
            step(1, 1, 16'(v), 3, 1, 0);
            if (v % 2 == 1) step(1, 0, 0, 3, 1, 0);
        end
        for (int k = 0; k < 3; k++) step(1, 0, 0, 3, 1, 0);
        chk("d3_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("d3_first", 32'(got[0]), 32'd10);
            chk("d3_second", 32'(got[1]), 32'd13);
            chk("d3_third", 32'(got[2]), 32'd16);
        end

        // Full FIFO with simultaneous push and pop: no drop, new sample lands last.
        step(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 8; k++) step(1, 1, 16'(200 + k), 1, 0, 0);
        step(1, 1, 16'd208, 1, 1, 0);
        chk("fullpp_level", 32'(level), 32'd8);
        chk("fullpp_head", 32'(out_data), 32'd201);
        chk("fullpp_drop", 32'(drop_count), 32'd0);
        got.delete();
        for (int k = 0; k < 8; k++) step(1, 0, 0, 1, 1, 0);
        chk("fullpp_count", 32'(got.size()), 32'd8);
        if (got.size() == 8) chk("fullpp_last", 32'(got[7]), 32'd208);

        // Clear coinciding with a drop, then a clean clear.
        step(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 13; k++) step(1, 1, 16'(400 + k), 1, 0, 0);
        chk("drop5_count", 32'(drop_count), 32'd5);
        step(1, 1, 16'd499, 1, 0, 1);
        chk("clrdrop_ovf", 32'(overflow), 32'd1);
        chk("clrdrop_count", 32'(drop_count), 32'd1);
        step(1, 0, 0, 1, 0, 1);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_count", 32'(drop_count), 32'd0);
        for (int k = 0; k < 8; k++) step(1, 0, 0, 1, 1, 0);

        // Mid-operation reset with a strobe, then a D=2 run keeps its first sample.
        for (int k = 0; k < 5; k++) step(1, 1, 16'(300 + k), 1, 0, 0);
        step(0, 1, 16'd77, 1, 1, 0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        got.delete();
        for (int v = 50; v <= 53; v++) step(1, 1, 16'(v), 2, 1, 0);
        for (int k = 0; k < 2; k++) step(1, 0, 0, 2, 1, 0);
        chk("d2_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("d2_first", 32'(got[0]), 32'd50);
            chk("d2_second", 32'(got[1]), 32'd52);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
